// File: rtl/reg_bank_ab_pkg.sv
// Shared constants for the register bank and the register-destination select mux.
package reg_bank_ab_pkg;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NREGS = 32;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;
    localparam logic [AW-1:0] REG_SP   = 5'd29;
    localparam logic [AW-1:0] REG_RA   = 5'd31;

    localparam logic [DW-1:0] SP_RESET = 32'd227;

endpackage

// File: rtl/reg_bank_ab_if.sv
// Register bank port bundle: write port, two read ports, A/B latch control and outputs.
interface reg_bank_ab_if;
    import reg_bank_ab_pkg::*;

    logic          reg_write;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read_reg1;
    logic [AW-1:0] read_reg2;
    logic          load_ab;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    logic [AW-1:0] last_wr_reg;

    modport master (
        output reg_write, write_reg, write_data, read_reg1, read_reg2, load_ab,
        input  read_data1, read_data2, a_out, b_out, last_wr_reg
    );

    modport slave (
        input  reg_write, write_reg, write_data, read_reg1, read_reg2, load_ab,
        output read_data1, read_data2, a_out, b_out, last_wr_reg
    );

endinterface

// File: rtl/reg_bank_ab_ab_latch.sv
// Operand latch: DW-bit register with synchronous active-low reset and load enable.
module ab_latch
    import reg_bank_ab_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_bank_ab.sv
// 32x32 MIPS register bank with built-in A/B operand latches.
// Define REG_BANK_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_bank_ab #(
    parameter logic [31:0] SP_RESET = reg_bank_ab_pkg::SP_RESET
) (
    input  logic         clk,
    input  logic         reset_n,
    reg_bank_ab_if.slave bus
);
    import reg_bank_ab_pkg::*;

    logic [DW-1:0] regs [NREGS];
    logic [AW-1:0] last_wr_reg_q;
    logic          wr_en_c;
    logic [DW-1:0] rd1_c;
    logic [DW-1:0] rd2_c;

    // Reg 0 is hard-wired: writes to it are dropped entirely.
    assign wr_en_c = bus.reg_write && (bus.write_reg != REG_ZERO);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[AW'(i)] <= (AW'(i) == REG_SP) ? SP_RESET : '0;
            end
            last_wr_reg_q <= '0;
        end else if (wr_en_c) begin
            regs[bus.write_reg] <= bus.write_data;
            last_wr_reg_q       <= bus.write_reg;
        end
    end

    // Zero-latency read ports.
    always_comb begin
        rd1_c = (bus.read_reg1 == REG_ZERO) ? '0 : regs[bus.read_reg1];
        rd2_c = (bus.read_reg2 == REG_ZERO) ? '0 : regs[bus.read_reg2];
`ifdef REG_BANK_BYPASS_EN
        if (wr_en_c && (bus.write_reg == bus.read_reg1)) rd1_c = bus.write_data;
        if (wr_en_c && (bus.write_reg == bus.read_reg2)) rd2_c = bus.write_data;
`endif
    end

    assign bus.read_data1  = rd1_c;
    assign bus.read_data2  = rd2_c;
    assign bus.last_wr_reg = last_wr_reg_q;

    ab_latch u_a_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (bus.load_ab),
        .d       (rd1_c),
        .q       (bus.a_out)
    );

    ab_latch u_b_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (bus.load_ab),
        .d       (rd2_c),
        .q       (bus.b_out)
    );

endmodule
